// File: rtl/btn_debounce.sv
// btn_debounce: synchronises a bouncy button, samples it on each tick_clk rising edge
// and accepts a new level after SAMPLES agreeing samples, with press/release pulses.
module btn_debounce #(
    parameter int SAMPLES     = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic n_rst,
    input  logic tick_clk,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);
    localparam int CW = $clog2(SAMPLES + 1);

    typedef enum logic [1:0] {STABLE_LOW, CHECK_HIGH, STABLE_HIGH, CHECK_LOW} state_t;

    state_t                 state;
    logic [1:0]             tick_sync;
    logic                   tick_prev;
    logic [SYNC_STAGES-1:0] btn_sr;
    logic [CW-1:0]          cnt;
    logic                   sample_en;
    logic                   btn_sync;
    logic                   last;

    assign sample_en = tick_sync[1] & ~tick_prev;
    assign btn_sync  = btn_sr[SYNC_STAGES-1];
    // the sample now being taken is the SAMPLES-th agreeing one
    assign last      = cnt == CW'(SAMPLES - 1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tick_sync <= '0;
            tick_prev <= 1'b0;
            btn_sr    <= '0;
        end else begin
            tick_sync <= {tick_sync[0], tick_clk};
            tick_prev <= tick_sync[1];
            btn_sr    <= {btn_sr[SYNC_STAGES-2:0], btn_in};
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= STABLE_LOW;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            if (sample_en) begin
                case (state)
                    STABLE_LOW: if (btn_sync) begin
                        state <= CHECK_HIGH;
                        cnt   <= CW'(1);
                    end
                    CHECK_HIGH: if (!btn_sync) begin
                        state <= STABLE_LOW;
                        cnt   <= '0;
                    end else if (last) begin
                        state     <= STABLE_HIGH;
                        cnt       <= '0;
                        btn_level <= 1'b1;
                        btn_press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    STABLE_HIGH: if (!btn_sync) begin
                        state <= CHECK_LOW;
                        cnt   <= CW'(1);
                    end
                    CHECK_LOW: if (btn_sync) begin
                        state <= STABLE_HIGH;
                        cnt   <= '0;
                    end else if (last) begin
                        state       <= STABLE_LOW;
                        cnt         <= '0;
                        btn_level   <= 1'b0;
                        btn_release <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                    default: state <= STABLE_LOW;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: directed table of per-sample button values plus hand sequences
// for strobe timing, reset behaviour and a stalled tick_clk.
module tb_btn_debounce;
    logic clk = 1'b0;
    logic n_rst, tick_clk, btn_in;
    logic btn_level, btn_press, btn_release;
    int   tests = 0;
    int   fails = 0;

    btn_debounce #(.SAMPLES(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tick_clk   (tick_clk),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic btn;
        logic lvl;
        int   np;
        int   nr;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic b, input logic l, input int p, input int r);
        vec_t v;
        v.btn = b; v.lvl = l; v.np = p; v.nr = r;
        vecs.push_back(v);
    endtask

    // one 10-clk tick_clk period: low half lets btn_in settle, high half triggers the sample
    task automatic do_sample(input logic b, output int np, output int nr);
        np = 0;
        nr = 0;
        btn_in   = b;
        tick_clk = 1'b0;
        repeat (5) begin
            @(negedge clk);
            np += int'(btn_press);
            nr += int'(btn_release);
        end
        tick_clk = 1'b1;
        repeat (5) begin
            @(negedge clk);
            np += int'(btn_press);
            nr += int'(btn_release);
        end
    endtask

    initial begin
        int np, nr;
        // bounce 1,1,0,1,1,1,1 from low
        add(1, 0, 0, 0); add(1, 0, 0, 0); add(0, 0, 0, 0); add(1, 0, 0, 0);
        add(1, 0, 0, 0); add(1, 0, 0, 0); add(1, 1, 1, 0);
        // clean release
        add(0, 1, 0, 0); add(0, 1, 0, 0); add(0, 1, 0, 0); add(0, 0, 0, 1);
        // clean press back to high
        add(1, 0, 0, 0); add(1, 0, 0, 0); add(1, 0, 0, 0); add(1, 1, 1, 0);
        // 0,0,1 bounce must return to STABLE_HIGH with count discarded
        add(0, 1, 0, 0); add(0, 1, 0, 0); add(1, 1, 0, 0);
        add(0, 1, 0, 0); add(0, 1, 0, 0); add(0, 1, 0, 0); add(0, 0, 0, 1);

        // reset held with button high and tick toggling
        n_rst    = 1'b0;
        btn_in   = 1'b1;
        tick_clk = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i % 3 == 2) tick_clk = ~tick_clk;
            check($sformatf("reset_outs[%0d]", i), {btn_level, btn_press, btn_release}, 0);
        end
        btn_in   = 1'b0;
        tick_clk = 1'b0;
        n_rst    = 1'b1;
        repeat (3) @(negedge clk);

        foreach (vecs[i]) begin
            do_sample(vecs[i].btn, np, nr);
            check($sformatf("vec[%0d] level", i), btn_level, vecs[i].lvl);
            check($sformatf("vec[%0d] press", i), np, vecs[i].np);
            check($sformatf("vec[%0d] release", i), nr, vecs[i].nr);
        end

        // clean press with cycle-exact strobe-to-pulse timing on the 4th sample
        for (int i = 0; i < 3; i++) begin
            do_sample(1'b1, np, nr);
            check($sformatf("clean_pre[%0d] press", i), np, 0);
        end
        btn_in   = 1'b1;
        tick_clk = 1'b0;
        repeat (5) @(negedge clk);
        tick_clk = 1'b1;
        @(negedge clk);
        check("clean_edge_k press", btn_press, 0);
        @(negedge clk);
        check("clean_edge_k1 press", btn_press, 0);
        check("clean_edge_k1 level", btn_level, 0);
        @(negedge clk);
        check("clean_edge_k2 press", btn_press, 1);
        check("clean_edge_k2 level", btn_level, 1);
        @(negedge clk);
        check("clean_edge_k3 press", btn_press, 0);
        check("clean_edge_k3 level", btn_level, 1);

        // reset after 3 of 4 high samples discards the partial count
        tick_clk = 1'b0;
        n_rst    = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_clears_level", btn_level, 0);
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_sample(1'b1, np, nr);
            check($sformatf("mid_pre[%0d] press", i), np, 0);
        end
        tick_clk = 1'b0;
        n_rst    = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_rst outs", {btn_level, btn_press, btn_release}, 0);
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_sample(1'b1, np, nr);
            check($sformatf("mid_post[%0d] press", i), np, 0);
            check($sformatf("mid_post[%0d] level", i), btn_level, 0);
        end
        do_sample(1'b1, np, nr);
        check("mid_post[3] press", np, 1);
        check("mid_post[3] level", btn_level, 1);

        // tick_clk high through reset release: one sample only, then stalled
        n_rst    = 1'b0;
        tick_clk = 1'b1;
        btn_in   = 1'b1;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        np = 0;
        nr = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            btn_in = (i % 8) >= 4;
            np += int'(btn_press);
            nr += int'(btn_release);
        end
        check("static press", np, 0);
        check("static release", nr, 0);
        check("static level", btn_level, 0);
        for (int i = 0; i < 2; i++) begin
            do_sample(1'b1, np, nr);
            check($sformatf("static_post[%0d] press", i), np, 0);
        end
        do_sample(1'b1, np, nr);
        check("static_post[2] press", np, 1);
        check("static_post[2] level", btn_level, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
